// File: rtl/iopage_pkg.sv
// Shared types and helpers for the I/O-page bus sequencer: FSM states,
// address width, PSW register addresses and byte-lane alignment.
package iopage_pkg;

    localparam int IOPAGE_AW = 13;

    localparam logic [IOPAGE_AW-1:0] PSW_ADDR     = 13'o17776;
    localparam logic [IOPAGE_AW-1:0] PSW_ADDR_ALT = 13'o17774;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        NXM_WAIT,
        DONE
    } state_t;

    // A byte write replicates the low byte onto both lanes so the device
    // can pick whichever lane its address selects.
    function automatic logic [15:0] align_wdata(input logic byte_op,
                                                input logic [15:0] wdata);
        logic [15:0] result;
        if (byte_op)
            result = {wdata[7:0], wdata[7:0]};
        else
            result = wdata;
        return result;
    endfunction

    function automatic logic [15:0] align_rdata(input logic byte_op,
                                                input logic odd,
                                                input logic [15:0] data);
        logic [15:0] result;
        if (!byte_op)
            result = data;
        else if (odd)
            result = {8'h00, data[15:8]};
        else
            result = {8'h00, data[7:0]};
        return result;
    endfunction

endpackage

// File: rtl/iopage_arb_rr.sv
// Two-way round-robin picker with its own last-grant history register.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       grant_in,
    output logic       grant,
    output logic       any
);

    logic last_grant;

    // Starting from 1 means master 0 wins the first contested pick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last_grant <= 1'b1;
        else if (update)
            last_grant <= grant_in;
    end

    always_comb begin
        any = |req;
        if (req == 2'b11)
            grant = ~last_grant;
        else
            grant = req[1];
    end

endmodule

// File: rtl/iopage_arb.sv
// Shares the 13-bit I/O-page register bus between the CPU (port 0) and the
// console/DMA master (port 1), with strobe sequencing and NXM timeout.
module iopage_arb
    import iopage_pkg::*;
#(
    parameter int NDEV       = 4,
    parameter int NXM_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           m_req,
    input  logic [1:0]           m_we,
    input  logic [1:0]           m_byte,
    input  logic [25:0]          m_addr,
    input  logic [31:0]          m_wdata,
    output logic [1:0]           m_ack,
    output logic                 m_nxm,
    output logic [15:0]          m_rdata,
    output logic [IOPAGE_AW-1:0] iopage_addr,
    output logic                 iopage_rd,
    output logic                 iopage_wr,
    output logic                 iopage_byte_op,
    output logic [15:0]          iopage_data,
    input  logic [NDEV-1:0]      dev_decode,
    input  logic [16*NDEV-1:0]   dev_data
);

    state_t state, next_state;

    logic                 arb_grant;
    logic                 arb_any;
    logic                 arb_update;

    logic                 lat_grant;
    logic                 lat_we;
    logic                 lat_byte;
    logic [IOPAGE_AW-1:0] lat_addr;
    logic [15:0]          lat_wdata;

    logic [7:0]           nxm_cnt;
    logic                 latch_en;
    logic                 cnt_load;
    logic                 cnt_dec;
    logic                 capture;
    logic                 finish;
    logic                 finish_nxm;
    logic [15:0]          dev_or;

    rr_arb2 u_rr (
        .clk      (clk),
        .reset    (reset),
        .req      (m_req),
        .update   (arb_update),
        .grant_in (lat_grant),
        .grant    (arb_grant),
        .any      (arb_any)
    );

    // Overlapping decode hits are tolerated: their data simply ORs together.
    always_comb begin
        dev_or = '0;
        for (int i = 0; i < NDEV; i++)
            dev_or = dev_or | dev_data[16*i +: 16];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        iopage_rd  = 1'b0;
        iopage_wr  = 1'b0;
        latch_en   = 1'b0;
        arb_update = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        capture    = 1'b0;
        finish     = 1'b0;
        finish_nxm = 1'b0;
        case (state)
            IDLE: begin
                if (arb_any) begin
                    latch_en   = 1'b1;
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                // An odd word address can never be decoded, so fail it
                // without waiting out the timeout.
                if (!lat_byte && lat_addr[0]) begin
                    finish     = 1'b1;
                    finish_nxm = 1'b1;
                    next_state = DONE;
                end else if (|dev_decode) begin
                    iopage_rd  = ~lat_we;
                    iopage_wr  = lat_we;
                    capture    = 1'b1;
                    finish     = 1'b1;
                    next_state = DONE;
                end else begin
                    cnt_load   = 1'b1;
                    next_state = NXM_WAIT;
                end
            end
            NXM_WAIT: begin
                if (nxm_cnt == 8'd0) begin
                    finish     = 1'b1;
                    finish_nxm = 1'b1;
                    next_state = DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            DONE: begin
                arb_update = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_grant <= 1'b0;
            lat_we    <= 1'b0;
            lat_byte  <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (latch_en) begin
            lat_grant <= arb_grant;
            lat_we    <= m_we[arb_grant];
            lat_byte  <= m_byte[arb_grant];
            lat_addr  <= arb_grant ? m_addr[25:13] : m_addr[12:0];
            lat_wdata <= arb_grant ? m_wdata[31:16] : m_wdata[15:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            nxm_cnt <= 8'd0;
        else if (cnt_load)
            nxm_cnt <= 8'(NXM_CYCLES - 1);
        else if (cnt_dec)
            nxm_cnt <= nxm_cnt - 8'd1;
    end

    // Completion outputs are registered so they appear during the DONE cycle
    // and are zero at all other times.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ack   <= 2'b00;
            m_nxm   <= 1'b0;
            m_rdata <= 16'h0000;
        end else begin
            m_ack   <= finish ? (2'b01 << lat_grant) : 2'b00;
            m_nxm   <= finish & finish_nxm;
            m_rdata <= capture ? align_rdata(lat_byte, lat_addr[0], dev_or) : 16'h0000;
        end
    end

    assign iopage_addr    = lat_addr;
    assign iopage_byte_op = lat_byte;
    assign iopage_data    = align_wdata(lat_byte, lat_wdata);

endmodule

// File: tb/tb_iopage_arb.sv
// Randomized self-checking bench for iopage_arb against a transaction-level
// model of grants, latency, strobes, alignment and NXM reporting.
module tb_iopage_arb;

    localparam int NDEV       = 4;
    localparam int NXM_CYCLES = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  m_req = '0;
    logic [1:0]  m_we = '0;
    logic [1:0]  m_byte = '0;
    logic [25:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [1:0]  m_ack;
    logic        m_nxm;
    logic [15:0] m_rdata;
    logic [12:0] iopage_addr;
    logic        iopage_rd;
    logic        iopage_wr;
    logic        iopage_byte_op;
    logic [15:0] iopage_data;
    logic [NDEV-1:0]    dev_decode = '0;
    logic [16*NDEV-1:0] dev_data = '0;

    int checks = 0;
    int passed = 0;
    int model_last = 1;

    iopage_arb #(.NDEV(NDEV), .NXM_CYCLES(NXM_CYCLES)) dut (
        .clk            (clk),
        .reset          (reset),
        .m_req          (m_req),
        .m_we           (m_we),
        .m_byte         (m_byte),
        .m_addr         (m_addr),
        .m_wdata        (m_wdata),
        .m_ack          (m_ack),
        .m_nxm          (m_nxm),
        .m_rdata        (m_rdata),
        .iopage_addr    (iopage_addr),
        .iopage_rd      (iopage_rd),
        .iopage_wr      (iopage_wr),
        .iopage_byte_op (iopage_byte_op),
        .iopage_data    (iopage_data),
        .dev_decode     (dev_decode),
        .dev_data       (dev_data)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp)
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        else
            passed++;
    endtask

    // One complete single-master transaction, checked against the model.
    task automatic applyStimulus(input int m, input bit we, input bit bop,
                                 input logic [12:0] addr, input logic [15:0] wdata,
                                 input logic [NDEV-1:0] dec, input logic [16*NDEV-1:0] dd);
        logic [15:0] ored, exp_rd, exp_wd;
        bit odd_err, nxm_err, got_ack, both;
        int exp_lat, lat, strobes;
        logic s_rd, s_wr, s_bop;
        logic [12:0] s_addr;
        logic [15:0] s_data;
        logic [1:0]  a_ack;
        logic        a_nxm;
        logic [15:0] a_rdata;

        ored = '0;
        for (int i = 0; i < NDEV; i++)
            if (dec[i]) ored = ored | dd[16*i +: 16];
        odd_err = !bop && addr[0];
        nxm_err = odd_err || (dec == 0);
        exp_lat = (!odd_err && dec == 0) ? 2 + NXM_CYCLES : 2;
        if (nxm_err)       exp_rd = 16'h0000;
        else if (!bop)     exp_rd = ored;
        else if (addr[0])  exp_rd = {8'h00, ored[15:8]};
        else               exp_rd = {8'h00, ored[7:0]};
        exp_wd = bop ? {wdata[7:0], wdata[7:0]} : wdata;

        @(negedge clk);
        dev_decode = dec;
        dev_data = dd;
        m_addr[13*m +: 13] = addr;
        m_wdata[16*m +: 16] = wdata;
        m_we[m] = we;
        m_byte[m] = bop;
        m_req[m] = 1'b1;

        got_ack = 0; both = 0; strobes = 0; lat = 0;
        s_rd = 0; s_wr = 0; s_bop = 0; s_addr = '0; s_data = '0;
        a_ack = '0; a_nxm = 0; a_rdata = '0;
        for (int c = 1; c <= 60 && !got_ack; c++) begin
            @(negedge clk);
            if (iopage_rd && iopage_wr) both = 1;
            if (iopage_rd || iopage_wr) begin
                strobes++;
                s_rd = iopage_rd; s_wr = iopage_wr;
                s_bop = iopage_byte_op; s_addr = iopage_addr; s_data = iopage_data;
            end
            if (m_ack != 2'b00) begin
                got_ack = 1; lat = c;
                a_ack = m_ack; a_nxm = m_nxm; a_rdata = m_rdata;
            end
        end
        if (!got_ack) begin
            checkOutput("ack_timeout", 32'd0, 32'd1);
        end else begin
            checkOutput("latency", lat, exp_lat);
            checkOutput("ack_port", a_ack, 2'b01 << m);
            checkOutput("nxm", a_nxm, nxm_err);
            if (!we || nxm_err) checkOutput("rdata", a_rdata, exp_rd);
        end
        checkOutput("strobe_cnt", strobes, nxm_err ? 0 : 1);
        checkOutput("rd_wr_overlap", both, 0);
        if (!nxm_err && strobes == 1) begin
            checkOutput("strobe_kind", {s_rd, s_wr}, we ? 2'b01 : 2'b10);
            checkOutput("io_addr", s_addr, addr);
            checkOutput("io_byte_op", s_bop, bop);
            if (we) checkOutput("io_wdata", s_data, exp_wd);
        end
        @(posedge clk);
        #1;
        m_req[m] = 1'b0;
        model_last = m;
    endtask

    initial begin
        int n, exp_g;
        bit ovl, got;
        logic [NDEV-1:0] dec;
        logic [16*NDEV-1:0] dd;
        logic [12:0] a;

        repeat (3) @(negedge clk);
        checkOutput("reset_outputs",
                    {m_ack, m_nxm, m_rdata, iopage_rd, iopage_wr, iopage_byte_op},
                    '0);
        checkOutput("reset_bus", {iopage_addr, iopage_data}, '0);
        reset = 1'b0;

        // Directed cases from the plan
        applyStimulus(0, 1, 0, 13'o17776, 16'o000340, 4'b0001, 64'h0);
        applyStimulus(1, 0, 0, 13'o17776, 16'h0, 4'b0001, {48'h0, 16'o170017});
        applyStimulus(0, 0, 1, 13'o17777, 16'h0, 4'b0001, {48'h0, 16'hA55A});
        applyStimulus(1, 1, 1, 13'o17776, 16'h0033, 4'b0001, 64'h0);
        applyStimulus(0, 0, 0, 13'o10000, 16'h0, 4'b0000, 64'h0);
        applyStimulus(1, 1, 0, 13'o17777, 16'h1234, 4'b0001, 64'h0);
        applyStimulus(0, 0, 0, 13'o17774, 16'h0, 4'b0101, {16'h0, 16'h0F00, 16'h0, 16'h00F1});

        // Both masters requesting continuously must alternate.
        @(negedge clk);
        dev_decode = 4'b0001;
        dev_data = {48'h0, 16'h1234};
        m_addr = {13'o17776, 13'o17776};
        m_we = 2'b00; m_byte = 2'b00;
        m_req = 2'b11;
        n = 0; ovl = 0;
        for (int c = 0; c < 60 && n < 4; c++) begin
            @(negedge clk);
            if (iopage_rd && iopage_wr) ovl = 1;
            if (m_ack != 2'b00) begin
                exp_g = 1 - model_last;
                checkOutput("rr_grant", m_ack, 2'b01 << exp_g);
                model_last = exp_g;
                n++;
            end
        end
        checkOutput("rr_count", n, 4);
        checkOutput("rr_overlap", ovl, 0);
        @(posedge clk);
        #1;
        m_req = 2'b00;

        // Randomized transactions
        for (int t = 0; t < 24; t++) begin
            case ($urandom_range(0, 3))
                0: a = 13'o17776;
                1: a = 13'o17777;
                2: a = 13'o17774;
                default: a = 13'($urandom);
            endcase
            dec = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            dd = '0;
            for (int i = 0; i < NDEV; i++)
                if (dec[i]) dd[16*i +: 16] = 16'($urandom);
            applyStimulus($urandom_range(0, 1), 1'($urandom), 1'($urandom), a,
                          16'($urandom), dec, dd);
        end

        // Reset while waiting out an NXM timeout abandons the transaction.
        @(negedge clk);
        dev_decode = '0;
        dev_data = '0;
        m_addr[12:0] = 13'o10000;
        m_we[0] = 1'b0; m_byte[0] = 1'b0;
        m_req[0] = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        m_req = 2'b00;
        #1;
        checkOutput("midreset_outputs",
                    {m_ack, m_nxm, m_rdata, iopage_rd, iopage_wr, iopage_byte_op},
                    '0);
        checkOutput("midreset_bus", {iopage_addr, iopage_data}, '0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_last = 1;
        got = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (m_ack != 2'b00) got = 1;
        end
        checkOutput("no_stale_ack", got, 0);
        applyStimulus(0, 0, 0, 13'o17776, 16'h0, 4'b0010, {32'h0, 16'hBEEF, 16'h0});

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/iopage_arb.md
Name: iopage_arb

Overview:
- Sequences and shares the 13-bit I/O-page register bus (PSW register block and sibling device register blocks) between two bus masters: port 0 = CPU, port 1 = console/DMA.
- Grants one master at a time using round-robin arbitration.
- Drives one-cycle iopage_rd/iopage_wr strobes, aligns byte data, and merges device read data.
- Signals a non-existent-memory (NXM) error when no device decodes the address.

Parameters:
- NDEV, 4: number of device register blocks attached (width of dev_decode).
- NXM_CYCLES, 8: idle cycles counted before NXM is reported on an undecoded address; legal range 1..255.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- m_req  in  2  per-master request; held high until ack
- m_we  in  2  per-master write (1) / read (0)
- m_byte  in  2  per-master byte operation
- m_addr  in  26  per-master I/O-page address; master i uses bits [13i+12:13i]
- m_wdata  in  32  per-master write data; master i uses bits [16i+15:16i]
- m_ack  out  2  one-cycle completion pulse to the granted master
- m_nxm  out  1  error flag, valid only while m_ack is high
- m_rdata  out  16  read data, valid only while m_ack is high
- iopage_addr  out  13  address to the device blocks
- iopage_rd  out  1  read strobe
- iopage_wr  out  1  write strobe
- iopage_byte_op  out  1  byte qualifier
- iopage_data  out  16  write data to the devices
- dev_decode  in  NDEV  per-device decode hit
- dev_data  in  16*NDEV  per-device read data; zero when the device is not decoded

Behaviour:
- Reset (asynchronous): state=IDLE, last_grant=1, all outputs 0, NXM counter 0.
- States: IDLE, ACCESS, NXM_WAIT, DONE.
- IDLE:
  - If any m_req is high, pick the grant. Both requesting: the master that is not last_grant wins. One requesting: that master wins.
  - Latch the granted master's addr, we, byte and wdata, then go to ACCESS.
- ACCESS:
  - Drive iopage_addr and iopage_byte_op from the latched values for the whole transaction.
  - Word access with addr[0]=1 is an odd-address error: no strobe, set nxm, go to DONE.
  - Else if |dev_decode:
    - Assert iopage_rd (read) or iopage_wr (write) for exactly this one cycle.
    - Capture the OR of all dev_data slices into the read register.
    - Go to DONE.
  - Else: load the counter with NXM_CYCLES-1 and go to NXM_WAIT.
- NXM_WAIT:
  - Decrement the counter; no strobes.
  - At 0: set nxm, read data = 0, go to DONE.
- DONE:
  - m_ack[grant]=1 for one cycle, with m_rdata and m_nxm valid.
  - last_grant := grant; go to IDLE.
  - m_ack is registered (high during the DONE cycle).
- Latency: request sampled in IDLE at edge k → strobe in cycle k+1 → ack in cycle k+2. NXM ack arrives at k+2+NXM_CYCLES.
- The master must drop m_req at the edge where it samples m_ack. A req still high in IDLE after DONE is treated as a new request.
- Write data alignment: byte op drives iopage_data = {wdata[7:0], wdata[7:0]}; word op drives wdata unchanged.
- Read alignment:
  - byte, even address: {8'b0, data[7:0]}
  - byte, odd address: {8'b0, data[15:8]}
  - word: data unchanged
- Multiple decode hits: data is ORed; no error is raised.
- m_req changes for the non-granted master during a transaction: ignored until IDLE.
- Reset mid-transaction: strobes and ack drop immediately. The transaction is abandoned with no ack; the master must reissue it.
- iopage_rd and iopage_wr are never both high. Neither is high outside ACCESS.

Decomposition:
- Shared package iopage_pkg holds:
  - state enum (IDLE, ACCESS, NXM_WAIT, DONE)
  - IOPAGE_AW=13
  - PSW address constants 13'o17776 and 13'o17774
  - byte-lane alignment functions
- Sub-module rr_arb2 contains the 2-way round-robin pick and last_grant register. Inputs: req[1:0], update, grant_in. Outputs: grant index, any.

Test Plan:
- Master 0 word write to 13'o17776 with wdata=16'o000340, dev_decode[0]=1 → iopage_wr high for exactly 1 cycle, iopage_data=16'o000340, m_ack[0] 2 cycles after acceptance, m_nxm=0.
- Master 1 word read of 13'o17776 with dev_data[0]=16'o170017 → iopage_rd pulse, m_rdata=16'o170017, m_ack[1]=1.
- Byte read of 13'o17777 with dev data 16'hA55A → m_rdata=16'h00A5. Byte write of 16'h0033 → iopage_data=16'h3333, iopage_byte_op=1.
- Read of 13'o10000 with dev_decode=0 and NXM_CYCLES=8 → no strobe, ack 10 cycles after acceptance, m_nxm=1, m_rdata=0. Word access to 13'o17777 → ack at k+2 with m_nxm=1 and no strobe.
- Both masters request continuously for 4 transactions → grants alternate 0,1,0,1 (first grant is 0 after reset), with no strobe overlap.
- Assert reset during NXM_WAIT → all outputs 0 immediately, state IDLE. A new request after reset completes normally.
